// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder
//   Decodes received UART key bytes into held movement directions and a
//   small FIFO of action commands.
//
//   Parameters
//     FIFO_DEPTH  action-command FIFO entries (power of two, 2..16)
//     HOLD_TICKS  ticks a direction stays active after its last key byte (1..15)
//
//   Ports
//     clk        system clock
//     reset_n    asynchronous active-low reset
//     rx_data    received byte, qualified by rx_valid
//     rx_valid   one-cycle strobe for rx_data
//     tick       one-cycle movement-rate enable
//     cmd_ready  consumer accepts the head action command
//     clr_ovf    clears the sticky overflow flag
//     move       active directions {right, left, down, up}
//     cmd_valid  action FIFO non-empty
//     cmd_code   head action code (1 confirm, 2 cancel, 3 menu), 0 when empty
//     overflow   sticky: an action byte was dropped
//
//   Build option
//     KEY_CASE_FOLD_EN  when defined, uppercase W/S/A/D/X decode like lowercase
module key_cmd_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tick,
  input  logic       cmd_ready,
  input  logic       clr_ovf,
  output logic [3:0] move,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       overflow
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned DIRS   = 4;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [CODE_W-1:0] CODE_CONFIRM = 2'd1;
  localparam logic [CODE_W-1:0] CODE_CANCEL  = 2'd2;
  localparam logic [CODE_W-1:0] CODE_MENU    = 2'd3;

  // Decoded byte: one-hot direction or non-zero action code
  logic [DIRS-1:0]   keyDir;
  logic [CODE_W-1:0] actCode;

  // Movement hold state
  logic [DIRS-1:0][HOLD_W-1:0] holdCnt;
  logic [DIRS-1:0][HOLD_W-1:0] holdCntNext;
  logic [DIRS-1:0]             moveNext;

  // Action FIFO state
  logic [CODE_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, wrPtrNext;
  logic [PTR_W-1:0]  rdPtr, rdPtrNext;
  logic [CNT_W-1:0]  fifoCnt, fifoCntNext;
  logic              popReq, pushReq, pushOk, ovfSet, isFull;
  logic              cmdValidNext;
  logic [CODE_W-1:0] headNext, cmdCodeNext;
  logic              overflowNext;

  // Byte decode; unknown bytes leave both outputs at zero
  always_comb begin
    keyDir  = '0;
    actCode = '0;
    if (rx_valid) begin
      case (rx_data)
        8'h77: keyDir  = 4'b0001;
        8'h73: keyDir  = 4'b0010;
        8'h61: keyDir  = 4'b0100;
        8'h64: keyDir  = 4'b1000;
        8'h20: actCode = CODE_CONFIRM;
        8'h78: actCode = CODE_CANCEL;
        8'h0D: actCode = CODE_MENU;
`ifdef KEY_CASE_FOLD_EN
        8'h57: keyDir  = 4'b0001;
        8'h53: keyDir  = 4'b0010;
        8'h41: keyDir  = 4'b0100;
        8'h44: keyDir  = 4'b1000;
        8'h58: actCode = CODE_CANCEL;
`endif
        default: ;
      endcase
    end
  end

  // Hold counters: a key reloads its own counter and kills the opposite
  // direction (index ^ 1); reload has priority over a coincident tick
  always_comb begin
    holdCntNext = holdCnt;
    moveNext    = '0;
    for (int d = 0; d < DIRS; d++) begin
      if (keyDir[2'(d)]) begin
        holdCntNext[2'(d)] = HOLD_LOAD;
      end else if (keyDir[2'(d ^ 1)]) begin
        holdCntNext[2'(d)] = '0;
      end else if (tick && (holdCnt[2'(d)] != '0)) begin
        holdCntNext[2'(d)] = holdCnt[2'(d)] - HOLD_W'(1);
      end
      moveNext[2'(d)] = (holdCntNext[2'(d)] != '0);
    end
  end

  // FIFO control; a pop frees the slot so a push into a full FIFO still lands
  always_comb begin
    popReq   = cmd_valid && cmd_ready;
    pushReq  = (actCode != '0);
    isFull   = (fifoCnt == DEPTH_CNT);
    pushOk   = pushReq && (!isFull || popReq);
    ovfSet   = pushReq && isFull && !popReq;

    wrPtrNext   = pushOk ? wrPtr + PTR_W'(1) : wrPtr;
    rdPtrNext   = popReq ? rdPtr + PTR_W'(1) : rdPtr;
    fifoCntNext = fifoCnt;
    if (pushOk && !popReq) begin
      fifoCntNext = fifoCnt + CNT_W'(1);
    end else if (!pushOk && popReq) begin
      fifoCntNext = fifoCnt - CNT_W'(1);
    end

    // The new head is the byte being written when it lands at the read slot
    headNext     = (pushOk && (rdPtrNext == wrPtr)) ? actCode : fifoMem[rdPtrNext];
    cmdValidNext = (fifoCntNext != '0);
    cmdCodeNext  = cmdValidNext ? headNext : '0;

    // A new drop wins over a coincident clear
    overflowNext = overflow;
    if (ovfSet) begin
      overflowNext = 1'b1;
    end else if (clr_ovf) begin
      overflowNext = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdCnt   <= '0;
      move      <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      holdCnt   <= holdCntNext;
      move      <= moveNext;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      fifoCnt   <= fifoCntNext;
      cmd_valid <= cmdValidNext;
      cmd_code  <= cmdCodeNext;
      overflow  <= overflowNext;
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= actCode;
    end
  end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// tb_key_cmd_decoder
//   Directed bench for key_cmd_decoder with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   that same point, i.e. after the edge that registered the stimulus.
module tb_key_cmd_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tick;
  logic       cmd_ready;
  logic       clr_ovf;
  logic [3:0] move;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       overflow;

  int checkCnt;
  int errCnt;

  key_cmd_decoder #(
    .FIFO_DEPTH(4),
    .HOLD_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tick     (tick),
    .cmd_ready(cmd_ready),
    .clr_ovf  (clr_ovf),
    .move     (move),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic tickOnce();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic checkFifo(input string tag, input logic v, input logic [1:0] c);
    checkVal({tag, "_valid"}, 8'(cmd_valid), 8'(v));
    checkVal({tag, "_code"},  8'(cmd_code),  8'(c));
  endtask

  initial begin
    checkCnt  = 0;
    errCnt    = 0;
    reset_n   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tick      = 1'b0;
    cmd_ready = 1'b0;
    clr_ovf   = 1'b0;

    // Reset state, including with stimulus present under reset
    #2;
    checkVal("rst_move", 8'(move), 8'h0);
    checkFifo("rst", 1'b0, 2'd0);
    checkVal("rst_ovf", 8'(overflow), 8'h0);
    rx_data = 8'h77; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    checkVal("rst_hold_move", 8'(move), 8'h0);
    reset_n = 1'b1;

    // Up key then expiry on the third tick
    sendByte(8'h77);
    checkVal("up_set", 8'(move), 8'h1);
    tickOnce();
    checkVal("up_tick1", 8'(move), 8'h1);
    step();
    checkVal("up_idle", 8'(move), 8'h1);
    tickOnce();
    checkVal("up_tick2", 8'(move), 8'h1);
    tickOnce();
    checkVal("up_tick3", 8'(move), 8'h0);

    // Down cancels up
    sendByte(8'h77);
    step();
    sendByte(8'h73);
    checkVal("down_cancels_up", 8'(move), 8'h2);
    tickOnce(); tickOnce();
    checkVal("down_tick2", 8'(move), 8'h2);
    tickOnce();
    checkVal("down_expire", 8'(move), 8'h0);

    // Reload wins over a coincident tick at counter=1
    sendByte(8'h64);
    checkVal("right_set", 8'(move), 8'h8);
    tickOnce(); tickOnce();
    checkVal("right_cnt1", 8'(move), 8'h8);
    rx_data = 8'h64; rx_valid = 1'b1; tick = 1'b1;
    step();
    rx_valid = 1'b0; tick = 1'b0;
    checkVal("right_reload", 8'(move), 8'h8);
    tickOnce(); tickOnce();
    checkVal("right_reload_t2", 8'(move), 8'h8);
    tickOnce();
    checkVal("right_reload_t3", 8'(move), 8'h0);

    // Left cancels right
    sendByte(8'h64);
    sendByte(8'h61);
    checkVal("left_cancels_right", 8'(move), 8'h4);
    tickOnce(); tickOnce(); tickOnce();
    checkVal("left_expire", 8'(move), 8'h0);

    // Ignored byte and optional uppercase fold
    sendByte(8'h77);
    sendByte(8'h51);
    checkVal("ignore_0x51", 8'(move), 8'h1);
    checkFifo("ignore_0x51", 1'b0, 2'd0);
    sendByte(8'h41);
`ifdef KEY_CASE_FOLD_EN
    checkVal("upper_A", 8'(move), 8'h5);
`else
    checkVal("upper_A", 8'(move), 8'h1);
`endif
    tickOnce(); tickOnce(); tickOnce();
    checkVal("fold_expire", 8'(move), 8'h0);

    // Fill FIFO, overflow, drain in order, clear overflow
    sendByte(8'h20);
    checkFifo("push1", 1'b1, 2'd1);
    sendByte(8'h78);
    sendByte(8'h0D);
    sendByte(8'h20);
    checkFifo("full", 1'b1, 2'd1);
    checkVal("full_ovf", 8'(overflow), 8'h0);
    sendByte(8'h78);
    checkVal("ovf_set", 8'(overflow), 8'h1);
    checkFifo("ovf_head", 1'b1, 2'd1);
    cmd_ready = 1'b1;
    step();
    checkFifo("drain2", 1'b1, 2'd2);
    step();
    checkFifo("drain3", 1'b1, 2'd3);
    step();
    checkFifo("drain4", 1'b1, 2'd1);
    step();
    checkFifo("drained", 1'b0, 2'd0);
    step();
    checkFifo("ready_when_empty", 1'b0, 2'd0);
    checkVal("ovf_sticky", 8'(overflow), 8'h1);
    cmd_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checkVal("ovf_clear", 8'(overflow), 8'h0);

    // Push with pop request while empty: entry stored
    cmd_ready = 1'b1;
    sendByte(8'h78);
    checkFifo("push_pop_empty", 1'b1, 2'd2);
    step();
    checkFifo("push_pop_empty_drain", 1'b0, 2'd0);
    cmd_ready = 1'b0;

    // Push and pop together while full: no overflow
    sendByte(8'h20);
    sendByte(8'h78);
    sendByte(8'h0D);
    sendByte(8'h20);
    cmd_ready = 1'b1;
    sendByte(8'h0D);
    checkVal("full_push_pop_ovf", 8'(overflow), 8'h0);
    checkFifo("fpp_head", 1'b1, 2'd2);
    step();
    checkFifo("fpp_d2", 1'b1, 2'd3);
    step();
    checkFifo("fpp_d3", 1'b1, 2'd1);
    step();
    checkFifo("fpp_last", 1'b1, 2'd3);
    step();
    checkFifo("fpp_empty", 1'b0, 2'd0);
    cmd_ready = 1'b0;

    // New overflow beats coincident clear
    sendByte(8'h20);
    sendByte(8'h78);
    sendByte(8'h0D);
    sendByte(8'h20);
    clr_ovf = 1'b1;
    sendByte(8'h0D);
    clr_ovf = 1'b0;
    checkVal("ovf_vs_clr", 8'(overflow), 8'h1);

    // Async reset mid-hold with a full FIFO discards everything
    sendByte(8'h77);
    checkVal("pre_rst_move", 8'(move), 8'h1);
    #3;
    reset_n = 1'b0;
    #1;
    checkVal("async_rst_move", 8'(move), 8'h0);
    checkFifo("async_rst", 1'b0, 2'd0);
    checkVal("async_rst_ovf", 8'(overflow), 8'h0);
    step();
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    step(); step();
    checkFifo("post_rst", 1'b0, 2'd0);
    checkVal("post_rst_move", 8'(move), 8'h0);
    cmd_ready = 1'b0;

    // First byte after release is decoded
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    sendByte(8'h73);
    checkVal("first_after_rst", 8'(move), 8'h2);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/key_cmd_decoder.md
KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: action-command FIFO entries, power of two, 2..16.
REQ-002 Parameter HOLD_TICKS, default 3: tick count a movement direction stays active after its last key byte, 1..15.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-007 tick  input  1  one-cycle movement-rate enable (10 Hz domain pulse, synchronous to clk).
REQ-008 cmd_ready  input  1  consumer accepts the head action command.
REQ-009 clr_ovf  input  1  clears the overflow flag.
REQ-010 move  output  4  active directions {right, left, down, up}, bit 0 = up.
REQ-011 cmd_valid  output  1  action FIFO non-empty.
REQ-012 cmd_code  output  2  head action code: 1 confirm, 2 cancel, 3 menu.
REQ-013 overflow  output  1  sticky: an action byte was dropped.

Function
REQ-014 Byte decode on rx_valid: 0x77 up, 0x73 down, 0x61 left, 0x64 right, 0x20 confirm, 0x78 cancel, 0x0D menu; every other byte is ignored with no state change.
REQ-015 Movement byte: set the direction bit and reload its 4-bit hold counter to HOLD_TICKS on the next clk edge.
REQ-016 Movement byte: clear the opposite direction bit and its counter in the same cycle (up/down, left/right).
REQ-017 On tick, each non-zero hold counter decrements by 1; a direction bit clears in the cycle its counter reaches 0.
REQ-018 Reload and tick on the same direction in the same cycle: reload wins; the counter equals HOLD_TICKS.
REQ-019 move is registered; it reflects a key byte one cycle after rx_valid.
REQ-020 Action byte: push its code into the FIFO; cmd_valid rises one cycle after the push into an empty FIFO.
REQ-021 Pop occurs when cmd_valid and cmd_ready are both high; the next entry appears on cmd_code the following cycle.
REQ-022 cmd_code is 0 whenever cmd_valid is low.
REQ-023 Push while full without a pop: drop the byte, set overflow, leave FIFO contents unchanged.
REQ-024 Push and pop in the same cycle while full: both are accepted; no overflow.
REQ-025 Push and pop in the same cycle while empty: pop is ignored; the pushed entry is stored.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with one extra counter bit so that full and empty are distinct.
REQ-027 overflow clears on clr_ovf; clr_ovf and a new overflow in the same cycle: overflow stays set.
REQ-028 cmd_ready is ignored while cmd_valid is low.

Reset
REQ-029 reset_n low asynchronously forces move=0, all hold counters to 0, FIFO empty (cmd_valid=0, cmd_code=0), overflow=0.
REQ-030 Reset asserted mid-hold or with a non-empty FIFO discards all state; no command is emitted after release.
REQ-031 The first rx_valid after the rising edge of reset_n is decoded normally.

Configuration
REQ-032 Macro KEY_CASE_FOLD_EN: when defined, uppercase 0x57/0x53/0x41/0x44/0x58 decode identically to their lowercase keys; when undefined, those bytes are ignored.

Verification
REQ-033 Reset release, byte 0x77 -> move=0001 next cycle; after 3 ticks without repeat -> move=0000 exactly in the cycle after the 3rd tick.
REQ-034 0x77, then 0x73 two cycles later -> move=0010; up counter is 0.
REQ-035 0x64 with tick in the same cycle while right counter=1 -> move[3]=1, counter=3.
REQ-036 Push 0x20,0x78,0x0D,0x20 with cmd_ready=0 -> FIFO full; a fifth 0x78 -> overflow=1; drain -> codes 1,2,3,1; clr_ovf -> overflow=0.
REQ-037 Full FIFO, cmd_ready=1 and 0x0D in the same cycle -> overflow stays 0; the last drained code is 3.
REQ-038 Build with and without KEY_CASE_FOLD_EN, send 0x41 -> move=0100 when defined, move=0000 when undefined; 0x51 -> no change in either build.
